// File: rtl/m_uart_tx_port.sv
// Memory-mapped UART transmitter with a 4-deep byte FIFO.
// The register window sits at BASE_ADDR: TXDATA at +0 and STATUS at +4.
module m_uart_tx_port #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0200,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_we,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wd,
    output logic        o_hit,
    output logic [31:0] o_rd,
    output logic        o_tx
);

    localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;

    logic sel_txdata, sel_status;
    logic push_req, push, pop;
    logic full, empty, busy;
    logic unused_bits;

    assign unused_bits = ^{i_wd[31:8], i_address[1:0]};

    assign o_hit      = (i_address[31:3] == BASE_ADDR[31:3]);
    assign sel_txdata = o_hit && !i_address[2];
    assign sel_status = o_hit && i_address[2];

    assign full  = (count_q == 3'd4);
    assign empty = (count_q == 3'd0);
    assign busy  = (state_q != StIdle);

    assign o_rd = sel_status ? {25'd0, count_q, ovf_q, empty, full, busy} : 32'd0;
    assign o_tx = tx_q;

    // A push uses the pre-edge full flag, so a same-edge pop never rescues it.
    always_comb begin
        push_req = i_we && sel_txdata;
        push     = push_req && !full;
        ovf_d    = ovf_q;
        if (i_we && sel_status && i_wd[0]) begin
            ovf_d = 1'b0;
        end
        if (push_req && full) begin
            ovf_d = 1'b1;
        end
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_wd[7:0];
        end
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = 16'd0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = 16'd0;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = 16'd0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is derived from the next state so the flop output is glitch-free.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_m_uart_tx_port.sv
// Randomized bench for m_uart_tx_port against a queue-based frame model.
module tb_m_uart_tx_port;

    localparam int unsigned    CPB  = 4;
    localparam logic [31:0]    BASE = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wd = 32'd0;
    logic        hit;
    logic [31:0] rd;
    logic        tx;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO as a queue, current frame as byte + elapsed cycles.
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_active;
    int         m_elapsed;
    logic [7:0] m_cur;

    m_uart_tx_port #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_we     (we),
        .i_address(addr),
        .i_wd     (wd),
        .o_hit    (hit),
        .o_rd     (rd),
        .o_tx     (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_elapsed / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    function automatic logic [31:0] exp_status();
        logic [2:0] cnt;
        cnt = 3'(mq.size());
        return {25'd0, cnt, m_ovf, (mq.size() == 0), (mq.size() == 4), m_active};
    endfunction

    function automatic logic exp_hit(input logic [31:0] a);
        return a[31:3] == BASE[31:3];
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return (exp_hit(a) && a[2]) ? exp_status() : 32'd0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf     = 1'b0;
        m_active  = 1'b0;
        m_elapsed = 0;
        m_cur     = 8'd0;
    endtask

    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit push_req;
        bit pre_full;
        push_req = w && exp_hit(a) && !a[2];
        pre_full = (mq.size() == 4);
        if (w && exp_hit(a) && a[2] && d[0]) m_ovf = 1'b0;
        if (push_req && pre_full) m_ovf = 1'b1;
        if (m_active) begin
            m_elapsed++;
            if (m_elapsed == 10 * CPB) m_active = 1'b0;
        end else if (mq.size() > 0) begin
            m_cur     = mq.pop_front();
            m_active  = 1'b1;
            m_elapsed = 0;
        end
        if (push_req && !pre_full) mq.push_back(d[7:0]);
    endtask

    // Called at posedge+1: drive, check combinational read, clock, check line.
    task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
        we   = w;
        addr = a;
        wd   = d;
        #1;
        check_eq("hit", 32'(hit), 32'(exp_hit(a)));
        check_eq("rd", rd, exp_rd(a));
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        check_eq("tx", 32'(tx), 32'(exp_tx()));
    endtask

    task automatic status_is(input string tag, input logic [31:0] exp);
        we   = 1'b0;
        addr = BASE + 32'd4;
        #1;
        check_eq(tag, rd, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, BASE + 32'd4, 32'd0);
    endtask

    task automatic pulse_reset();
        we    = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("tx_in_reset", 32'(tx), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("tx_during_reset", 32'(tx), 32'd1);
        rst_n = 1'b1;

        // Reset state
        status_is("reset_status", 32'h0000_0004);
        check_eq("reset_hit", 32'(hit), 32'd1);
        check_eq("reset_tx", 32'(tx), 32'd1);

        // Single frame 0x55
        cycle(1'b1, BASE, 32'h0000_0055);
        idle(1);
        check_eq("start_low", 32'(tx), 32'd0);
        idle(41);
        status_is("single_done", 32'h0000_0004);

        // Overflow: 6 writes back to back, last one dropped
        for (int i = 1; i <= 6; i++) cycle(1'b1, BASE, 32'(i));
        status_is("ovf_status", 32'h0000_004B);
        cycle(1'b1, BASE + 32'd4, 32'h0000_0000);
        status_is("ovf_keep", 32'h0000_004B);
        cycle(1'b1, BASE + 32'd4, 32'h0000_0001);
        status_is("ovf_clear", 32'h0000_0043);
        idle(5 * 41 + 5);
        status_is("ovf_drained", 32'h0000_0004);

        // Miss
        cycle(1'b1, 32'h0000_0010, 32'h0000_00AA);
        check_eq("miss_hit", 32'(hit), 32'd0);
        check_eq("miss_rd", rd, 32'd0);
        status_is("miss_status", 32'h0000_0004);
        idle(3);

        // Reset mid-frame, with more data queued behind it
        cycle(1'b1, BASE, 32'h0000_00C3);
        cycle(1'b1, BASE, 32'h0000_003C);
        idle(12);
        pulse_reset();
        status_is("post_reset_status", 32'h0000_0004);
        idle(100);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 199);
            if (r < 30) begin
                cycle(1'b1, BASE, $urandom());
            end else if (r < 40) begin
                cycle(1'b1, BASE + 32'd4, $urandom());
            end else if (r < 50) begin
                cycle(1'b1, {$urandom_range(0, 255), 24'h0}, $urandom());
            end else if (r < 52) begin
                pulse_reset();
            end else if (r < 120) begin
                cycle(1'b0, BASE + 32'(r[2:0]), $urandom());
            end else begin
                cycle(1'b0, BASE + 32'd4, 32'd0);
            end
        end
        idle(5 * 41 + 5);
        status_is("final_status", exp_status());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
